// File: rtl/frame_loader.sv
// frame_loader: validates sync/length/checksum framed bytes and atomically commits payload to data.
// A link watchdog blanks data when committed frames stop arriving.
module frame_loader #(
  parameter int         NUM_DATA_BITS = 20,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         BYTE_GAP      = 1000,
  parameter int         LINK_TIMEOUT  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] data [NUM_DATA_BITS],
  output logic       frame_ok,
  output logic       frame_err,
  output logic       link_up
);
  localparam int IW = $clog2(NUM_DATA_BITS) + 1;
  localparam int GW = $clog2(BYTE_GAP) + 1;
  localparam int WW = $clog2(LINK_TIMEOUT) + 1;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    sum_q, sum_d, sum_nx;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    shadow_q [NUM_DATA_BITS];
  logic [7:0]    shadow_d [NUM_DATA_BITS];
  logic [7:0]    data_q [NUM_DATA_BITS];
  logic [7:0]    data_d [NUM_DATA_BITS];
  logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d, link_up_q, link_up_d;
  logic          commit, expire;
  assign sum_nx    = sum_q + rx_byte;
  assign data      = data_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign link_up   = link_up_q;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    gap_d       = '0;
    shadow_d    = shadow_q;
    data_d      = data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    link_up_d   = link_up_q;
    commit      = 1'b0;
    expire      = 1'b0;
    case (state_q)
      HUNT: if (rx_valid && rx_byte == SYNC_BYTE) begin
        state_d = PAYLOAD;
        idx_d   = '0;
        sum_d   = '0;
      end
      PAYLOAD: if (rx_valid) begin
        for (int i = 0; i < NUM_DATA_BITS; i++)
          if (idx_q == IW'(i)) shadow_d[i] = rx_byte;
        sum_d   = sum_nx;
        idx_d   = idx_q + IW'(1);
        state_d = (idx_q == IW'(NUM_DATA_BITS - 1)) ? CHECK : PAYLOAD;
      end
      CHECK: if (rx_valid) begin
        commit      = (sum_nx == 8'h00);
        frame_err_d = !commit;
        state_d     = HUNT;
      end
      default: state_d = HUNT;
    endcase
    // Idle inside a frame: a gap of BYTE_GAP cycles abandons the partial frame
    if (state_q != HUNT && !rx_valid) begin
      gap_d = gap_q + GW'(1);
      if (gap_d == GW'(BYTE_GAP)) begin
        state_d     = HUNT;
        frame_err_d = 1'b1;
        gap_d       = '0;
      end
    end
    wd_d   = commit ? '0 : (wd_q == WW'(LINK_TIMEOUT)) ? wd_q : wd_q + WW'(1);
    expire = !commit && wd_q != WW'(LINK_TIMEOUT) && wd_d == WW'(LINK_TIMEOUT);
    if (commit) begin
      data_d     = shadow_q;
      frame_ok_d = 1'b1;
      link_up_d  = 1'b1;
    end else if (expire) begin
      for (int i = 0; i < NUM_DATA_BITS; i++) data_d[i] = '0;
      link_up_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      sum_q       <= '0;
      gap_q       <= '0;
      wd_q        <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      link_up_q   <= 1'b0;
      for (int i = 0; i < NUM_DATA_BITS; i++) begin
        shadow_q[i] <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      gap_q       <= gap_d;
      wd_q        <= wd_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      link_up_q   <= link_up_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed and random framed traffic checked against a queue-based frame model.
module tb_frame_loader;
  localparam int         N    = 20;
  localparam int         GAP  = 10;
  localparam int         LT   = 100;
  localparam int         DW   = 8 * N;
  localparam logic [7:0] SYNC = 8'hA5;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] data [N];
  logic       frame_ok, frame_err, link_up;
  int         n_checks = 0;
  int         n_pass = 0;
  string      phase = "reset";
  logic [7:0] pl [N];
  bit         m_in;
  logic [7:0] m_q [$];
  int         m_idle, m_since;
  logic [7:0] m_data [N];
  bit         m_link, e_ok, e_err;

  frame_loader #(.NUM_DATA_BITS(N), .SYNC_BYTE(SYNC), .BYTE_GAP(GAP), .LINK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .data(data), .frame_ok(frame_ok), .frame_err(frame_err), .link_up(link_up));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s/%s: got %0h expected %0h", phase, name, got, exp);
  endtask

  task automatic m_reset();
    m_in = 0; m_q.delete(); m_idle = 0; m_since = 0; m_link = 0; e_ok = 0; e_err = 0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
  endtask

  // One clock edge of the frame rules: sync hunt, N+1 bytes summing to zero, idle abort, watchdog.
  task automatic m_edge(input bit v, input logic [7:0] b);
    int  s;
    bit  com;
    com = 0; e_ok = 0; e_err = 0;
    if (!m_in) begin
      if (v && b == SYNC) begin m_in = 1; m_q.delete(); m_idle = 0; end
    end else if (v) begin
      m_q.push_back(b); m_idle = 0;
      if (m_q.size() == N + 1) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        if (s % 256 == 0) begin
          for (int i = 0; i < N; i++) m_data[i] = m_q[i];
          com = 1; e_ok = 1; m_link = 1; m_since = 0;
        end else e_err = 1;
        m_in = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == GAP) begin e_err = 1; m_in = 0; end
    end
    if (!com && m_since < LT) begin
      m_since++;
      if (m_since == LT) begin
        for (int i = 0; i < N; i++) m_data[i] = '0;
        m_link = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] g, e;
    for (int i = 0; i < N; i++) begin g[8*i +: 8] = data[i]; e[8*i +: 8] = m_data[i]; end
    check("frame_ok", DW'(frame_ok), DW'(e_ok));
    check("frame_err", DW'(frame_err), DW'(e_err));
    check("link_up", DW'(link_up), DW'(m_link));
    check("data", g, e);
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    rx_valid = v; rx_byte = b;
    @(posedge clk);
    m_edge(v, b);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom);
  endtask

  function automatic logic [7:0] chk_of();
    logic [7:0] s = '0;
    for (int i = 0; i < N; i++) s += pl[i];
    return -s;
  endfunction

  task automatic send_frame(input logic [7:0] c);
    step(1, SYNC);
    for (int i = 0; i < N; i++) step(1, pl[i]);
    step(1, c);
  endtask

  initial begin
    m_reset();
    #3 check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    phase = "valid";
    for (int i = 0; i < N; i++) pl[i] = 8'(i);
    send_frame(8'h42);
    check("ok_pulse", DW'(frame_ok), DW'(1));
    check("data5", DW'(data[5]), DW'(8'h05));
    step(0, 0);
    check("ok_low", DW'(frame_ok), DW'(0));

    phase = "badsum";
    send_frame(8'h43);
    check("err_pulse", DW'(frame_err), DW'(1));
    check("data19_kept", DW'(data[19]), DW'(8'h13));
    for (int i = 0; i < N; i++) pl[i] = 8'h07;
    send_frame(8'h74);
    check("all07", DW'(data[0]), DW'(8'h07));

    phase = "junk";
    step(1, 8'h00); step(1, 8'hFF); step(1, 8'h12);
    for (int i = 0; i < N; i++) pl[i] = 8'(i);
    pl[3] = SYNC;
    send_frame(chk_of());
    check("data3_sync", DW'(data[3]), DW'(SYNC));

    phase = "gap10";
    step(1, SYNC);
    for (int i = 0; i <= 5; i++) step(1, 8'(i + 1));
    idle(GAP - 1);
    check("no_err_yet", DW'(frame_err), DW'(0));
    idle(1);
    check("gap_err", DW'(frame_err), DW'(1));
    for (int i = 0; i < N; i++) pl[i] = 8'(3 * i + 1);
    send_frame(chk_of());

    phase = "gap9";
    for (int i = 0; i < N; i++) pl[i] = 8'(5 * i + 2);
    step(1, SYNC);
    for (int i = 0; i <= 5; i++) step(1, pl[i]);
    idle(GAP - 1);
    for (int i = 6; i < N; i++) step(1, pl[i]);
    step(1, chk_of());
    check("gap9_ok", DW'(frame_ok), DW'(1));

    phase = "watchdog";
    idle(LT - 1);
    check("link99", DW'(link_up), DW'(1));
    idle(1);
    check("link100", DW'(link_up), DW'(0));
    check("blank0", DW'(data[0]), DW'(0));
    for (int i = 0; i < N; i++) pl[i] = 8'(i + 9);
    send_frame(chk_of());
    idle(LT - (N + 2));
    for (int i = 0; i < N; i++) pl[i] = 8'(7 * i);
    send_frame(chk_of());
    check("edge_commit", DW'(link_up), DW'(1));
    check("edge_data1", DW'(data[1]), DW'(8'h07));

    phase = "rst_mid";
    for (int i = 0; i < N; i++) pl[i] = 8'(i);
    step(1, SYNC);
    for (int i = 0; i <= 10; i++) step(1, pl[i]);
    rx_valid = 0;
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 11; i < N; i++) step(1, pl[i]);
    step(1, 8'h42);
    for (int i = 0; i < N; i++) pl[i] = 8'(i + 8'h30);
    send_frame(chk_of());
    check("after_rst", DW'(data[2]), DW'(8'h32));

    phase = "random";
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
      for (int j = $urandom_range(0, 3); j > 0; j--) step($urandom_range(0, 1), 8'($urandom_range(0, 8'hA4)));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(LT - 5, LT + 5));
      step(1, SYNC);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) idle($urandom_range(GAP - 2, GAP + 1));
        step(1, pl[i]);
      end
      step(1, chk_of() + 8'($urandom_range(0, 3) == 0));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/frame_loader.md
# frame_loader

Receives the scoreboard state as framed bytes from the byte-level link receiver and maintains the 20-byte `data` array consumed by `segments`. Frames are validated by sync byte, length and checksum. Only complete, valid frames are committed, atomically and in one cycle, so the display never shows a half-updated frame. A link watchdog clears the array to all-zero (which `segments` renders as blank) when valid frames stop arriving.

## Interface
- `NUM_DATA_BITS`, default 20: payload bytes per frame; equals `data` array depth.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `BYTE_GAP`, default 1000: maximum idle cycles between bytes inside a frame.
- `LINK_TIMEOUT`, default 50_000_000: cycles without a committed frame before blanking.

Ports:
- `clk` input 1: single clock; all logic is synchronous to its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_byte` input 8: received byte; valid only when `rx_valid` is high.
- `rx_valid` input 1: one-cycle strobe; the byte is accepted on any cycle this is high (no back-pressure).
- `data` output [7:0] x `NUM_DATA_BITS`: committed payload; `data[i]` is payload byte i.
- `frame_ok` output 1: one-cycle pulse on commit.
- `frame_err` output 1: one-cycle pulse on checksum mismatch or byte-gap abort.
- `link_up` output 1: high from the first commit until watchdog expiry.

## Operation
- **Frame format:** `SYNC_BYTE`, then payload bytes 0..`NUM_DATA_BITS`-1, then a checksum byte C. The frame is valid iff (sum of payload + C) mod 256 == 0.
- **State machine:**
  - HUNT: discards bytes until `rx_byte`==`SYNC_BYTE`, then goes to PAYLOAD with index=0 and sum=0.
  - PAYLOAD: each accepted byte is written to shadow[index], sum is updated (8-bit wrap) and index is incremented. When the byte at index `NUM_DATA_BITS`-1 is accepted, the FSM goes to CHECK.
  - CHECK: the next accepted byte is the checksum.
    - Valid: shadow is copied to `data`, `frame_ok` pulses, the watchdog is cleared and `link_up` is set.
    - Invalid: `frame_err` pulses and `data` is unchanged.
    - In both cases the FSM returns to HUNT.
- A `SYNC_BYTE` value inside PAYLOAD or CHECK is treated as data. There is no mid-frame resynchronisation.
- **Gap counter:**
  - Runs only in PAYLOAD and CHECK. It resets to 0 on every accepted byte and increments otherwise.
  - When it reaches `BYTE_GAP`, the FSM goes to HUNT and `frame_err` pulses.
  - If `rx_valid` is high on the expiry cycle, the byte is accepted and there is no abort.
- **Link watchdog:**
  - Counts every cycle and saturates at `LINK_TIMEOUT`. It is cleared to 0 on commit.
  - On reaching `LINK_TIMEOUT`, all `data` bytes are set to 0 and `link_up` goes to 0. This happens once; the counter then stays saturated.
  - Commit and expiry on the same cycle: commit wins.
- The shadow buffer is separate from `data`, so `data` only ever holds a complete committed frame or all zeros.
- Counter widths: `$clog2` of the parameter + 1. Sum and index have no overflow beyond the wraps stated above.

## Timing
- **Reset values:**
  - `data` = all 0.
  - `frame_ok`, `frame_err`, `link_up` = 0.
  - FSM = HUNT; index, sum, gap and watchdog counters = 0.
  - Reset asserted mid-frame discards the partial frame.
- **Latency:** checksum byte accepted at edge k → `data`, `frame_ok` and `link_up` updated at edge k (visible in cycle k+1); `frame_ok` is deasserted at edge k+1.
- A gap abort asserts `frame_err` for exactly one cycle at the edge where the counter reaches `BYTE_GAP`.
- Back-to-back frames are supported: a sync byte in the cycle immediately after a checksum byte is accepted.
- Minimum frame duration: `NUM_DATA_BITS`+2 consecutive `rx_valid` cycles.
- The watchdog reaches `LINK_TIMEOUT` exactly `LINK_TIMEOUT` edges after the last commit (or after reset); `data` is zero from that edge.

## Test plan
- **Valid frame:** bytes A5, 00,01,…,13 (payload i=i, sum 0xBE), checksum 42, back-to-back → one `frame_ok` pulse the cycle after 42; `data[i]`==i; `link_up`=1.
- **Bad checksum:** same frame with checksum 43 → `frame_err` pulse; `data` still 0 (or the prior frame); `frame_ok` never asserted. A following valid frame with all payload bytes 07 and checksum 0x74 commits.
- **Junk and resync:** bytes 00, FF, 12 before A5 are ignored; an A5 at payload index 3 is stored as `data[3]`=A5 with the checksum adjusted to match → commit.
- **Byte gap:** `BYTE_GAP`=10, stop after payload byte 5 for 10 cycles → `frame_err` at the 10th idle edge. Resuming with a full valid frame commits. A separate run with a 9-cycle gap commits normally.
- **Watchdog:** `LINK_TIMEOUT`=100, commit, then idle → `data` all 0 and `link_up`=0 exactly 100 edges after commit. A checksum byte accepted on the 100th edge commits instead of blanking.
- **Reset mid-frame:** pull `rst_n` low asynchronously after payload byte 10 → outputs are at their reset values immediately. After release, the remaining bytes of the old frame are ignored in HUNT and the next full frame commits.
